// File: rtl/operand_issue_stage.sv
// Decode/operand-issue stage: splits MIPS fields, reads rs/rt and feeds the ALU through a 2-entry skid buffer.
// Optional: define WB_BYPASS_EN to forward a same-cycle writeback into the captured operands.
module operand_issue_stage #(
    parameter int DATA_W    = 32,
    parameter int REG_COUNT = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    input  logic [31:0]       instr,
    output logic              instr_ready,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              alu_valid,
    input  logic              alu_ready,
    output logic [5:0]        opcode,
    output logic [DATA_W-1:0] rs_content,
    output logic [DATA_W-1:0] rt_content,
    output logic [4:0]        shamt,
    output logic [5:0]        ALU_control,
    output logic [15:0]       immediate,
    output logic [4:0]        dest_addr
);

    localparam int AW = $clog2(REG_COUNT);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    typedef struct packed {
        logic [5:0]        opcode;
        logic [DATA_W-1:0] rs_val;
        logic [DATA_W-1:0] rt_val;
        logic [4:0]        shamt;
        logic [5:0]        alu_ctrl;
        logic [15:0]       imm;
        logic [4:0]        dest;
    } entry_t;

    state_t            state, state_next;
    entry_t            head, skid, new_entry;
    logic [DATA_W-1:0] regs [REG_COUNT];
    logic              ready_en;
    logic              accept, pop;
    logic              load_head_new, load_skid, shift_skid;

    logic [5:0] f_op;
    logic [4:0] f_rs, f_rt, f_rd, f_shamt;
    logic [5:0] f_funct;

    assign f_op    = instr[31:26];
    assign f_rs    = instr[25:21];
    assign f_rt    = instr[20:16];
    assign f_rd    = instr[15:11];
    assign f_shamt = instr[10:6];
    assign f_funct = instr[5:0];

    // ready_en keeps the stage closed while reset is held and opens it on the first edge after release.
    assign instr_ready = ready_en && (state != TWO);
    assign alu_valid   = (state != EMPTY);
    assign accept      = instr_valid && instr_ready;
    assign pop         = alu_valid && alu_ready;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        new_entry          = '0;
        new_entry.opcode   = f_op;
        new_entry.shamt    = f_shamt;
        new_entry.imm      = instr[15:0];
        new_entry.alu_ctrl = (f_op == 6'd0) ? f_funct : 6'd0;
        new_entry.dest     = (f_op == 6'd0) ? f_rd : f_rt;
        if (f_rs != 5'd0) new_entry.rs_val = regs[f_rs[AW-1:0]];
        if (f_rt != 5'd0) new_entry.rt_val = regs[f_rt[AW-1:0]];
`ifdef WB_BYPASS_EN
        if (wb_en && (wb_addr == f_rs) && (f_rs != 5'd0)) new_entry.rs_val = wb_data;
        if (wb_en && (wb_addr == f_rt) && (f_rt != 5'd0)) new_entry.rt_val = wb_data;
`endif
    end

    always_comb begin
        state_next    = state;
        load_head_new = 1'b0;
        load_skid     = 1'b0;
        shift_skid    = 1'b0;
        case (state)
            EMPTY: if (accept) begin
                state_next    = ONE;
                load_head_new = 1'b1;
            end
            ONE: begin
                if (accept && !pop) begin
                    state_next = TWO;
                    load_skid  = 1'b1;
                end else if (pop && !accept) begin
                    state_next = EMPTY;
                end else if (accept && pop) begin
                    load_head_new = 1'b1;
                end
            end
            TWO: if (pop) begin
                state_next = ONE;
                shift_skid = 1'b1;
            end
            default: state_next = EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            ready_en <= 1'b0;
            head     <= '0;
            skid     <= '0;
        end else begin
            state    <= state_next;
            ready_en <= 1'b1;
            if (load_head_new)   head <= new_entry;
            else if (shift_skid) head <= skid;
            if (load_skid)       skid <= new_entry;
        end
    end

    // NOTE: the register file is reset explicitly because reset must clear architectural state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else if (wb_en && (wb_addr != 5'd0)) begin
            regs[wb_addr[AW-1:0]] <= wb_data;
        end
    end

    assign opcode      = head.opcode;
    assign rs_content  = head.rs_val;
    assign rt_content  = head.rt_val;
    assign shamt       = head.shamt;
    assign ALU_control = head.alu_ctrl;
    assign immediate   = head.imm;
    assign dest_addr   = head.dest;

endmodule

// File: tb/tb_operand_issue_stage.sv
// Scoreboard bench for operand_issue_stage: directed issues push expected bundles, a negedge monitor compares the head.
module tb_operand_issue_stage;

    typedef struct {
        logic [5:0]  opcode;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [4:0]  shamt;
        logic [5:0]  ctrl;
        logic [15:0] imm;
        logic [4:0]  dest;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = '0;
    logic        instr_ready;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        alu_valid;
    logic        alu_ready = 1'b0;
    logic [5:0]  opcode;
    logic [31:0] rs_content, rt_content;
    logic [4:0]  shamt;
    logic [5:0]  ALU_control;
    logic [15:0] immediate;
    logic [4:0]  dest_addr;

    int checks = 0;
    int errors = 0;
    bundle_t q[$];

    operand_issue_stage #(.DATA_W(32), .REG_COUNT(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .opcode(opcode), .rs_content(rs_content), .rt_content(rt_content),
        .shamt(shamt), .ALU_control(ALU_control), .immediate(immediate),
        .dest_addr(dest_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bundle_t mk(input logic [5:0] op, input logic [31:0] rs, input logic [31:0] rt,
                                   input logic [4:0] sh, input logic [5:0] ctrl, input logic [15:0] imm,
                                   input logic [4:0] dest);
        bundle_t b;
        b.opcode = op; b.rs = rs; b.rt = rt; b.shamt = sh; b.ctrl = ctrl; b.imm = imm; b.dest = dest;
        return b;
    endfunction

    // Monitor: whenever a bundle is presented it must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && alu_valid) begin
            if (q.size() == 0) begin
                check("unexpected_bundle", 32'd1, 32'd0);
            end else begin
                check("opcode",      {26'd0, opcode},      {26'd0, q[0].opcode});
                check("rs_content",  rs_content,           q[0].rs);
                check("rt_content",  rt_content,           q[0].rt);
                check("shamt",       {27'd0, shamt},       {27'd0, q[0].shamt});
                check("ALU_control", {26'd0, ALU_control}, {26'd0, q[0].ctrl});
                check("immediate",   {16'd0, immediate},   {16'd0, q[0].imm});
                check("dest_addr",   {27'd0, dest_addr},   {27'd0, q[0].dest});
                if (alu_ready) void'(q.pop_front());
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the instruction.
    task automatic issue(input logic [31:0] ins, input bundle_t exp);
        logic was_ready;
        logic accepted = 1'b0;
        q.push_back(exp);
        instr       = ins;
        instr_valid = 1'b1;
        for (int i = 0; i < 20 && !accepted; i++) begin
            was_ready = instr_ready;
            @(posedge clk); #1;
            accepted = was_ready;
        end
        instr_valid = 1'b0;
        check("issue_accepted", {31'd0, accepted}, 32'd1);
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        @(posedge clk); #1;
        wb_en = 1'b0;
    endtask

    initial begin
        #3;
        check("rst_alu_valid",   {31'd0, alu_valid},   32'd0);
        check("rst_instr_ready", {31'd0, instr_ready}, 32'd0);
        check("rst_outputs", {opcode, shamt, ALU_control, immediate} | rs_content | rt_content | {27'd0, dest_addr}, 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_release", {31'd0, instr_ready}, 32'd1);

        // SRL rd=3 shamt=1 with r1=15, r2=12
        alu_ready = 1'b1;
        write_reg(5'd1, 32'd15);
        write_reg(5'd2, 32'd12);
        issue(32'h0022_1842, mk(6'd0, 32'd15, 32'd12, 5'd1, 6'b000010, 16'h1842, 5'd3));
        check("latency_srl", {31'd0, alu_valid}, 32'd1);

        // addi rt=4 with r1=23
        write_reg(5'd1, 32'd23);
        issue(32'h2024_0005, mk(6'b001000, 32'd23, 32'd0, 5'd0, 6'd0, 16'h0005, 5'd4));
        check("latency_addi", {31'd0, alu_valid}, 32'd1);
        @(posedge clk); #1;

        // Back-to-back issue into a stalled ALU
        alu_ready = 1'b0;
        issue(32'h0022_2820, mk(6'd0, 32'd23, 32'd12, 5'd0, 6'h20, 16'h2820, 5'd5));
        issue(32'h8C46_0010, mk(6'h23, 32'd12, 32'd0, 5'd0, 6'd0, 16'h0010, 5'd6));
        check("ready_low_when_full", {31'd0, instr_ready}, 32'd0);
        fork
            issue(32'h0041_3900, mk(6'd0, 32'd12, 32'd23, 5'd4, 6'd0, 16'h3900, 5'd7));
            begin
                repeat (3) @(posedge clk);
                #1 alu_ready = 1'b1;
            end
        join
        repeat (3) @(posedge clk); #1;
        check("drained_after_stall", q.size(), 32'd0);

        // Writeback to r1 in the same cycle as an accept reading r1
        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd35;
`ifdef WB_BYPASS_EN
        issue(32'h0022_4022, mk(6'd0, 32'd35, 32'd12, 5'd0, 6'h22, 16'h4022, 5'd8));
`else
        issue(32'h0022_4022, mk(6'd0, 32'd23, 32'd12, 5'd0, 6'h22, 16'h4022, 5'd8));
`endif
        wb_en = 1'b0;
        issue(32'h0022_4022, mk(6'd0, 32'd35, 32'd12, 5'd0, 6'h22, 16'h4022, 5'd8));

        // Writes to r0 are dropped, including in the accept cycle
        write_reg(5'd0, 32'd7);
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'd7;
        issue(32'h0000_4820, mk(6'd0, 32'd0, 32'd0, 5'd0, 6'h20, 16'h4820, 5'd9));
        wb_en = 1'b0;
        issue(32'h0000_4820, mk(6'd0, 32'd0, 32'd0, 5'd0, 6'h20, 16'h4820, 5'd9));
        repeat (2) @(posedge clk); #1;

        // Reset while both entries are held
        alu_ready = 1'b0;
        issue(32'h0022_2820, mk(6'd0, 32'd35, 32'd12, 5'd0, 6'h20, 16'h2820, 5'd5));
        issue(32'h8C46_0010, mk(6'h23, 32'd12, 32'd0, 5'd0, 6'd0, 16'h0010, 5'd6));
        check("full_before_reset", {31'd0, instr_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("reset_kills_valid", {31'd0, alu_valid}, 32'd0);
        q.delete();
        repeat (2) @(posedge clk); #1;
        rst_n     = 1'b1;
        alu_ready = 1'b1;
        repeat (4) @(posedge clk); #1;
        check("no_emit_after_reset", {31'd0, alu_valid}, 32'd0);

        // Register file was cleared by the reset
        issue(32'h0022_4022, mk(6'd0, 32'd0, 32'd0, 5'd0, 6'h22, 16'h4022, 5'd8));
        repeat (3) @(posedge clk); #1;
        check("queue_drained", q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
